// File: rtl/ysyx_23060077_riscv_id_imm_stage_pkg.sv
// Shared constants for the immediate-decode stage: XLEN default, opcodes, format codes.
package ysyx_23060077_riscv_id_imm_stage_pkg;

    localparam int unsigned XlenDefault = 32;

    localparam int unsigned ImmTypeW = 3;

    localparam logic [6:0] OpcLui     = 7'b0110111;
    localparam logic [6:0] OpcAuipc   = 7'b0010111;
    localparam logic [6:0] OpcJal     = 7'b1101111;
    localparam logic [6:0] OpcJalr    = 7'b1100111;
    localparam logic [6:0] OpcBranch  = 7'b1100011;
    localparam logic [6:0] OpcLoad    = 7'b0000011;
    localparam logic [6:0] OpcStore   = 7'b0100011;
    localparam logic [6:0] OpcOpImm   = 7'b0010011;
    localparam logic [6:0] OpcOpImm32 = 7'b0011011;
    localparam logic [6:0] OpcOp      = 7'b0110011;
    localparam logic [6:0] OpcOp32    = 7'b0111011;
    localparam logic [6:0] OpcFence   = 7'b0001111;
    localparam logic [6:0] OpcSystem  = 7'b1110011;

    typedef enum logic [ImmTypeW-1:0] {
        ImmNone = 3'd0,
        ImmI    = 3'd1,
        ImmS    = 3'd2,
        ImmB    = 3'd3,
        ImmU    = 3'd4,
        ImmJ    = 3'd5,
        ImmZ    = 3'd6
    } imm_type_e;

endpackage

// File: rtl/ysyx_23060077_riscv_imm_gen.sv
// Combinational immediate generator: instruction -> {immediate, format code, illegal flag}.
module ysyx_23060077_riscv_imm_gen
    import ysyx_23060077_riscv_id_imm_stage_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = XlenDefault
) (
    input  logic [31:0]           inst_i,
    output logic [DATA_WIDTH-1:0] imm_o,
    output logic [ImmTypeW-1:0]   imm_type_o,
    output logic                  illegal_o
);

    localparam bit Is64 = (DATA_WIDTH == 64);

    logic [6:0]  opcode;
    imm_type_e   imm_type;
    logic [31:0] imm32;

    assign opcode = inst_i[6:0];

    // Classify the opcode into an immediate format; anything unrecognised is illegal.
    always_comb begin
        imm_type  = ImmNone;
        illegal_o = 1'b0;
        if (inst_i[1:0] != 2'b11) begin
            illegal_o = 1'b1;
        end else begin
            case (opcode)
                OpcLui, OpcAuipc:           imm_type = ImmU;
                OpcJal:                     imm_type = ImmJ;
                OpcJalr, OpcLoad, OpcOpImm: imm_type = ImmI;
                OpcBranch:                  imm_type = ImmB;
                OpcStore:                   imm_type = ImmS;
                OpcOpImm32: begin
                    if (Is64) imm_type = ImmI;
                    else      illegal_o = 1'b1;
                end
                OpcOp, OpcFence:            imm_type = ImmNone;
                OpcOp32:                    illegal_o = !Is64;
                OpcSystem:                  imm_type = inst_i[14] ? ImmZ : ImmNone;
                default:                    illegal_o = 1'b1;
            endcase
        end
    end

    // Assemble the immediate at 32 bits; every format fits, so widening is a sign extension.
    always_comb begin
        imm32 = 32'b0;
        case (imm_type)
            ImmI: imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
            ImmS: imm32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
            ImmB: imm32 = {{20{inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
            ImmJ: imm32 = {{12{inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
            ImmU: imm32 = {inst_i[31:12], 12'b0};
            ImmZ: imm32 = {27'b0, inst_i[19:15]};
            default: imm32 = 32'b0;
        endcase
    end

    // Z has bit 31 clear, so the signed widening leaves it zero-extended.
    assign imm_o      = DATA_WIDTH'($signed(imm32));
    assign imm_type_o = imm_type;

endmodule

// File: rtl/ysyx_23060077_riscv_id_imm_stage.sv
// Registered immediate-decode stage with a two-entry skid buffer (main + skid).
module ysyx_23060077_riscv_id_imm_stage
    import ysyx_23060077_riscv_id_imm_stage_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = XlenDefault
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_inst,
    input  logic [DATA_WIDTH-1:0] in_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_imm,
    output logic [ImmTypeW-1:0]   out_imm_type,
    output logic                  out_illegal,
    output logic [DATA_WIDTH-1:0] out_pc,
    output logic [31:0]           out_inst
);

    if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
        $error("DATA_WIDTH must be 32 or 64");
    end

    typedef struct packed {
        logic [DATA_WIDTH-1:0] imm;
        logic [ImmTypeW-1:0]   imm_type;
        logic                  illegal;
        logic [DATA_WIDTH-1:0] pc;
        logic [31:0]           inst;
    } entry_t;

    entry_t main_q, main_d, skid_q, skid_d, dec;
    logic   out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
    logic   in_fire, main_free;

    ysyx_23060077_riscv_imm_gen #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_imm_gen (
        .inst_i     (in_inst),
        .imm_o      (dec.imm),
        .imm_type_o (dec.imm_type),
        .illegal_o  (dec.illegal)
    );

    assign dec.pc   = in_pc;
    assign dec.inst = in_inst;

    assign in_ready  = !skid_valid_q;
    assign in_fire   = in_valid && in_ready;
    assign main_free = !out_valid_q || out_ready;

    // Next-state: refill main from skid first (FIFO order), else from input; park input in skid.
    always_comb begin
        main_d       = main_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (main_free) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (in_fire) begin
                main_d      = dec;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
        end
    end

    // State registers with synchronous reset that discards anything in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            main_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            out_valid_q  <= out_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_imm      = main_q.imm;
    assign out_imm_type = main_q.imm_type;
    assign out_illegal  = main_q.illegal;
    assign out_pc       = main_q.pc;
    assign out_inst     = main_q.inst;

endmodule
